// File: rtl/uart_pkg.sv
// Shared types and helpers for the extended UART receiver: FSM state encoding,
// parity-mode codes, and the parity / majority helper functions.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Widest legal data word; narrower words are zero-extended, which leaves parity unchanged.
  localparam int PAR_W = 9;

  function automatic logic parity_bit(input logic [PAR_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: two-flop synchroniser for rx plus the capture register whose
// two stored samples are voted with the live third sample.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic rx,
  input  logic sample_en,
  output logic rx_s,
  output logic maj
);

  logic [1:0] sync_r;
  logic [1:0] cap_r;

  // Synchroniser and early-sample capture, both idling at the line's high level
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= 2'b11;
      cap_r  <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx};
      if (sample_en) begin
        cap_r <= {cap_r[0], sync_r[1]};
      end else begin
        cap_r <= cap_r;
      end
    end
  end

  assign rx_s = sync_r[1];
  assign maj  = majority3(cap_r[1], cap_r[0], sync_r[1]);

endmodule

// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver with majority voting, false-start rejection, runtime
// parity / stop-bit configuration and parity, framing and break reporting.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int DBIT = 8,
  parameter int OVS  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  input  logic [1:0]      parity_mode,
  input  logic            two_stop,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det
);

  localparam int SW = $clog2(OVS);
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
  localparam logic [SW-1:0] S_LO   = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVS / 2);
  localparam logic [SW-1:0] S_EVAL = SW'(OVS / 2 + 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  rx_state_t       state_r, state_nx;
  logic [SW-1:0]   s_r, s_nx, s_inc;
  logic [NW-1:0]   n_r, n_nx;
  logic [DBIT-1:0] b_r, b_nx, dout_nx;
  logic [1:0]      mode_r, mode_nx;
  logic            two_stop_r, two_stop_nx;
  logic            stop_idx_r, stop_idx_nx;
  logic            par_bit_r, par_bit_nx;
  logic            par_err_r, par_err_nx;
  logic            fe_r, fe_nx;
  logic            stop0_r, stop0_nx;
  logic            done_nx, perr_nx, ferr_nx, brk_nx;
  logic            rx_s, maj, sample_en, eval, bit_end, par_en, first_stop, brk;

  uart_rx_sampler u_sampler (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .sample_en (sample_en),
    .rx_s      (rx_s),
    .maj       (maj)
  );

  assign eval       = s_tick && (s_r == S_EVAL);
  assign bit_end    = s_tick && (s_r == S_LAST);
  assign sample_en  = s_tick && (state_r != IDLE) && (state_r != BRK_WAIT) &&
                      ((s_r == S_LO) || (s_r == S_MID));
  assign par_en     = (mode_r == PAR_EVEN) || (mode_r == PAR_ODD);
  assign first_stop = stop_idx_r ? stop0_r : maj;
  assign brk        = (b_r == {DBIT{1'b0}}) && (!par_en || !par_bit_r) && !first_stop;

  // Tick counter advance, wrapping at the end of each bit period
  always_comb begin
    s_inc = s_r;
    if (s_tick) begin
      s_inc = (s_r == S_LAST) ? {SW{1'b0}} : s_r + 1'b1;
    end else begin
      s_inc = s_r;
    end
  end

  // Next-state and frame-completion logic
  always_comb begin
    state_nx    = state_r;
    s_nx        = s_r;
    n_nx        = n_r;
    b_nx        = b_r;
    mode_nx     = mode_r;
    two_stop_nx = two_stop_r;
    stop_idx_nx = stop_idx_r;
    par_bit_nx  = par_bit_r;
    par_err_nx  = par_err_r;
    fe_nx       = fe_r;
    stop0_nx    = stop0_r;
    done_nx     = 1'b0;
    dout_nx     = dout;
    perr_nx     = parity_err;
    ferr_nx     = frame_err;
    brk_nx      = break_det;
    case (state_r)
      IDLE: begin
        s_nx = {SW{1'b0}};
        if (!rx_s) begin
          state_nx    = START;
          mode_nx     = parity_mode;
          two_stop_nx = two_stop;
          stop_idx_nx = 1'b0;
          par_bit_nx  = 1'b0;
          par_err_nx  = 1'b0;
          fe_nx       = 1'b0;
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        s_nx = s_inc;
        if (eval && maj) begin
          state_nx = IDLE;
          s_nx     = {SW{1'b0}};
        end else if (bit_end) begin
          state_nx = DATA;
          n_nx     = {NW{1'b0}};
        end else begin
          state_nx = START;
        end
      end
      DATA: begin
        s_nx = s_inc;
        if (eval) begin
          b_nx = {maj, b_r[DBIT-1:1]};
        end else begin
          b_nx = b_r;
        end
        if (bit_end && (n_r == N_LAST)) begin
          state_nx    = par_en ? PARITY : STOP;
          stop_idx_nx = 1'b0;
        end else if (bit_end) begin
          n_nx = n_r + 1'b1;
        end else begin
          state_nx = DATA;
        end
      end
      PARITY: begin
        s_nx = s_inc;
        if (eval) begin
          par_bit_nx = maj;
          par_err_nx = (maj != parity_bit(PAR_W'(b_r), mode_r == PAR_ODD));
        end else begin
          par_bit_nx = par_bit_r;
        end
        if (bit_end) begin
          state_nx = STOP;
        end else begin
          state_nx = PARITY;
        end
      end
      STOP: begin
        s_nx = s_inc;
        if (eval && (stop_idx_r == two_stop_r)) begin
          // Last stop bit: finish at its centre so a back-to-back start edge is not missed
          done_nx  = 1'b1;
          dout_nx  = b_r;
          perr_nx  = par_err_r;
          ferr_nx  = fe_r | ~maj | brk;
          brk_nx   = brk;
          state_nx = brk ? BRK_WAIT : IDLE;
          s_nx     = {SW{1'b0}};
        end else if (eval) begin
          fe_nx    = fe_r | ~maj;
          stop0_nx = maj;
        end else if (bit_end) begin
          stop_idx_nx = 1'b1;
        end else begin
          state_nx = STOP;
        end
      end
      BRK_WAIT: begin
        s_nx = {SW{1'b0}};
        if (rx_s) begin
          state_nx = IDLE;
        end else begin
          state_nx = BRK_WAIT;
        end
      end
      default: begin
        state_nx = IDLE;
        s_nx     = {SW{1'b0}};
      end
    endcase
  end

  // Frame-tracking registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      s_r        <= {SW{1'b0}};
      n_r        <= {NW{1'b0}};
      b_r        <= {DBIT{1'b0}};
      mode_r     <= PAR_NONE;
      two_stop_r <= 1'b0;
      stop_idx_r <= 1'b0;
      par_bit_r  <= 1'b0;
      par_err_r  <= 1'b0;
      fe_r       <= 1'b0;
      stop0_r    <= 1'b0;
    end else begin
      state_r    <= state_nx;
      s_r        <= s_nx;
      n_r        <= n_nx;
      b_r        <= b_nx;
      mode_r     <= mode_nx;
      two_stop_r <= two_stop_nx;
      stop_idx_r <= stop_idx_nx;
      par_bit_r  <= par_bit_nx;
      par_err_r  <= par_err_nx;
      fe_r       <= fe_nx;
      stop0_r    <= stop0_nx;
    end
  end

  // Registered outputs, held until the next completed frame
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_done_tick <= 1'b0;
      dout         <= {DBIT{1'b0}};
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      break_det    <= 1'b0;
    end else begin
      rx_done_tick <= done_nx;
      dout         <= dout_nx;
      parity_err   <= perr_nx;
      frame_err    <= ferr_nx;
      break_det    <= brk_nx;
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Randomised and directed frame bench for uart_rx_ext, checked against a
// frame-level model of the expected data word and error flags.
module tb_uart_rx_ext;

  localparam int DBIT   = 8;
  localparam int OVS    = 16;
  localparam int TDIV   = 4;
  localparam int BITCLK = OVS * TDIV;

  typedef struct packed {
    logic [DBIT-1:0] d;
    logic            pe;
    logic            fe;
    logic            bd;
  } res_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            rx;
  logic            s_tick;
  logic [1:0]      parity_mode;
  logic            two_stop;
  logic            rx_done_tick;
  logic [DBIT-1:0] dout;
  logic            parity_err;
  logic            frame_err;
  logic            break_det;

  int   checks = 0;
  int   errors = 0;
  res_t got_q[$];
  res_t exp_last;

  uart_rx_ext #(.DBIT(DBIT), .OVS(OVS)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .parity_mode  (parity_mode),
    .two_stop     (two_stop),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .break_det    (break_det)
  );

  always #5 clk = ~clk;

  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (TDIV - 1) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_done_tick) got_q.push_back({dout, parity_err, frame_err, break_det});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic good_par(input logic [DBIT-1:0] d, input logic [1:0] mode);
    return (^d) ^ (mode == 2'b10);
  endfunction

  function automatic res_t model(input logic [DBIT-1:0] d, input logic [1:0] mode,
                                 input logic tw, input logic p, input logic st0, input logic st1);
    res_t r;
    logic pen;
    pen  = (mode == 2'b01) || (mode == 2'b10);
    r.d  = d;
    r.pe = pen && (p != good_par(d, mode));
    r.bd = (d == '0) && (!pen || !p) && !st0;
    r.fe = !st0 || (tw && !st1) || r.bd;
    return r;
  endfunction

  task automatic send_frame(input logic [DBIT-1:0] d, input logic [1:0] mode, input logic tw,
                            input logic p, input logic st0, input logic st1, input int glitch_bit);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DBIT; i++) bits.push_back(d[i]);
    if ((mode == 2'b01) || (mode == 2'b10)) bits.push_back(p);
    bits.push_back(st0);
    if (tw) bits.push_back(st1);
    parity_mode = mode;
    two_stop    = tw;
    for (int i = 0; i < bits.size(); i++) begin
      // Scramble the configuration mid-frame; the receiver must keep what it latched
      if (i == 1) begin
        parity_mode = 2'($urandom);
        two_stop    = 1'($urandom);
      end
      if (i == DBIT + 1) begin
        parity_mode = mode;
        two_stop    = tw;
      end
      rx = bits[i];
      if (i == glitch_bit) begin
        hold(BITCLK / 2 - 1);
        rx = ~bits[i];
        hold(3);
        rx = bits[i];
        hold(BITCLK / 2 - 2);
      end else begin
        hold(BITCLK);
      end
    end
    rx = 1'b1;
  endtask

  task automatic expect_one(input string tag, input res_t e);
    res_t r;
    check_eq({tag, " pulses"}, got_q.size(), 32'd1);
    if (got_q.size() != 0) begin
      r = got_q.pop_front();
      check_eq({tag, " dout"}, r.d, e.d);
      check_eq({tag, " parity_err"}, r.pe, e.pe);
      check_eq({tag, " frame_err"}, r.fe, e.fe);
      check_eq({tag, " break_det"}, r.bd, e.bd);
    end
    got_q.delete();
    exp_last = e;
  endtask

  task automatic expect_none(input string tag);
    check_eq({tag, " pulses"}, got_q.size(), 32'd0);
    check_eq({tag, " dout held"}, dout, exp_last.d);
    check_eq({tag, " flags held"}, {parity_err, frame_err, break_det},
             {exp_last.pe, exp_last.fe, exp_last.bd});
    got_q.delete();
  endtask

  initial begin
    logic [DBIT-1:0] d;
    logic [1:0]      mode;
    logic            tw, p, st0, st1, last0;
    int              gap;

    reset       = 1'b1;
    rx          = 1'b1;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    exp_last    = '0;
    hold(5);
    check_eq("reset rx_done_tick", rx_done_tick, 1'b0);
    check_eq("reset dout", dout, '0);
    check_eq("reset flags", {parity_err, frame_err, break_det}, 3'b000);
    reset = 1'b0;
    hold(BITCLK);

    send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    expect_one("8N1 a5", model(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
    hold(BITCLK);

    send_frame(8'h3C, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, -1);
    expect_one("8E1 3c bad par", model(8'h3C, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1));
    send_frame(8'h3C, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    expect_one("8E1 3c good par", model(8'h3C, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1));
    hold(BITCLK);

    rx = 1'b0;
    hold(4 * TDIV);
    rx = 1'b1;
    hold(3 * BITCLK);
    expect_none("glitch");

    send_frame(8'h81, 2'b10, 1'b1, good_par(8'h81, 2'b10), 1'b1, 1'b0, -1);
    expect_one("8O2 81 stop2 low", model(8'h81, 2'b10, 1'b1, good_par(8'h81, 2'b10), 1'b1, 1'b0));
    send_frame(8'h7E, 2'b10, 1'b1, good_par(8'h7E, 2'b10), 1'b1, 1'b1, -1);
    expect_one("8O2 7e back-to-back", model(8'h7E, 2'b10, 1'b1, good_par(8'h7E, 2'b10), 1'b1, 1'b1));
    hold(BITCLK);

    parity_mode = 2'b00;
    two_stop    = 1'b0;
    rx          = 1'b0;
    hold(12 * BITCLK);
    rx = 1'b1;
    hold(2 * BITCLK);
    expect_one("break", model(8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));

    send_frame(8'hF0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 4);
    expect_one("noise f0", model(8'hF0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
    hold(BITCLK);

    // Abort 0x55 after its start bit and three data bits
    rx = 1'b0; hold(BITCLK);
    rx = 1'b1; hold(BITCLK);
    rx = 1'b0; hold(BITCLK);
    rx = 1'b1; hold(BITCLK);
    reset = 1'b1;
    rx    = 1'b1;
    hold(2);
    check_eq("midframe reset dout", dout, '0);
    check_eq("midframe reset flags", {parity_err, frame_err, break_det}, 3'b000);
    reset = 1'b0;
    hold(2 * BITCLK);
    exp_last = '0;
    expect_none("aborted 55");
    send_frame(8'hC3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    expect_one("c3 after reset", model(8'hC3, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
    hold(BITCLK);

    for (int k = 0; k < 24; k++) begin
      d    = DBIT'($urandom);
      mode = 2'($urandom_range(0, 3));
      tw   = 1'($urandom);
      p    = good_par(d, mode) ^ ($urandom_range(0, 3) == 0);
      st0  = ($urandom_range(0, 4) != 0);
      st1  = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0) begin
        d   = '0;
        p   = 1'b0;
        st0 = 1'b0;
      end
      send_frame(d, mode, tw, p, st0, st1, -1);
      expect_one($sformatf("rand%0d", k), model(d, mode, tw, p, st0, st1));
      last0 = tw ? !st1 : !st0;
      gap   = last0 ? $urandom_range(1, 2) : $urandom_range(0, 1);
      hold(gap * BITCLK);
    end

    hold(2 * BITCLK);
    check_eq("final no stray pulses", got_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
